// File: rtl/cpu_defs.sv
// Shared RISC CPU definitions: opcode constants, one-hot controller state
// encoding and the per-phase control strobe bundle.
package cpu_defs;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t HLT_OP  = 3'b000;
  localparam opcode_t SKZ_OP  = 3'b001;
  localparam opcode_t ADD_OP  = 3'b010;
  localparam opcode_t ANDD_OP = 3'b011;
  localparam opcode_t XORR_OP = 3'b100;
  localparam opcode_t LDA_OP  = 3'b101;
  localparam opcode_t STO_OP  = 3'b110;
  localparam opcode_t JMP_OP  = 3'b111;

  typedef enum logic [9:0] {
    IDLE = 10'b00_0000_0001,
    S0   = 10'b00_0000_0010,
    S1   = 10'b00_0000_0100,
    S2   = 10'b00_0000_1000,
    S3   = 10'b00_0001_0000,
    S4   = 10'b00_0010_0000,
    S5   = 10'b00_0100_0000,
    S6   = 10'b00_1000_0000,
    S7   = 10'b01_0000_0000,
    HALT = 10'b10_0000_0000
  } state_t;

  typedef struct packed {
    logic halt;
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic load_ir;
    logic rd;
    logic wr;
    logic datactl_ena;
  } ctl_t;

  function automatic logic is_alu_op(input opcode_t op);
    return (op == ADD_OP) || (op == ANDD_OP) || (op == XORR_OP) || (op == LDA_OP);
  endfunction

endpackage

// File: rtl/machine_ctl.sv
// Instruction-sequencing controller: locks an 8-phase machine cycle to the
// fetch strobe and drives registered per-phase datapath strobes.
module machine_ctl
  import cpu_defs::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch,
  input  logic [OP_W-1:0] opcode,
  input  logic          zero,
  output logic          inc_pc,
  output logic          load_pc,
  output logic          load_acc,
  output logic          load_ir,
  output logic          rd,
  output logic          wr,
  output logic          datactl_ena,
  output logic          halt
);

  state_t state, next;
  logic   fetch_d;
  logic   rise;
  ctl_t   ctl, ctl_next;

  // Strobes for the state being entered, so each is valid for exactly the
  // cycle the FSM sits in that state.
  function automatic ctl_t decode(input state_t s, input opcode_t op, input logic z);
    ctl_t c;
    c = '0;
    case (s)
      S0: begin
        c.rd      = 1'b1;
        c.load_ir = 1'b1;
      end
      S1: begin
        c.rd      = 1'b1;
        c.load_ir = 1'b1;
        c.inc_pc  = 1'b1;
      end
      S3: begin
        if (op == HLT_OP) c.halt   = 1'b1;
        else              c.inc_pc = 1'b1;
      end
      S4: begin
        if (is_alu_op(op))     c.rd          = 1'b1;
        else if (op == JMP_OP) c.load_pc     = 1'b1;
        else if (op == STO_OP) c.datactl_ena = 1'b1;
      end
      S5: begin
        if (is_alu_op(op)) begin
          c.rd       = 1'b1;
          c.load_acc = 1'b1;
        end else if (op == SKZ_OP) begin
          c.inc_pc = z;
        end else if (op == JMP_OP) begin
          c.load_pc = 1'b1;
          c.inc_pc  = 1'b1;
        end else if (op == STO_OP) begin
          c.datactl_ena = 1'b1;
          c.wr          = 1'b1;
        end
      end
      S6: begin
        if (is_alu_op(op))     c.rd          = 1'b1;
        else if (op == STO_OP) c.datactl_ena = 1'b1;
      end
      S7:      c.inc_pc = (op == SKZ_OP) && z;
      HALT:    c.halt   = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  assign rise = fetch & ~fetch_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      fetch_d <= 1'b0;
      ctl     <= '0;
    end else begin
      state   <= next;
      fetch_d <= fetch;
      ctl     <= ctl_next;
    end
  end

  // NOTE: defaults are assigned first so no path leaves next/ctl_next unassigned
  // and no latch is inferred.
  always_comb begin
    next     = state;
    ctl_next = '0;
    case (state)
      IDLE:    next = IDLE;
      S0:      next = S1;
      S1:      next = S2;
      S2:      next = S3;
      S3:      next = (opcode == HLT_OP) ? HALT : S4;
      S4:      next = S5;
      S5:      next = S6;
      S6:      next = S7;
      S7:      next = S0;
      HALT:    next = HALT;
      default: next = IDLE;
    endcase
    // A fetch rise re-anchors the machine cycle; misaligned ones abort the
    // instruction in flight. Only reset leaves HALT.
    if (rise && state != HALT) next = S0;
    ctl_next = decode(next, opcode, zero);
  end

  assign halt        = ctl.halt;
  assign inc_pc      = ctl.inc_pc;
  assign load_pc     = ctl.load_pc;
  assign load_acc    = ctl.load_acc;
  assign load_ir     = ctl.load_ir;
  assign rd          = ctl.rd;
  assign wr          = ctl.wr;
  assign datactl_ena = ctl.datactl_ena;

endmodule

// File: tb/tb_machine_ctl.sv
// Self-checking bench for machine_ctl: directed and random instruction streams
// compared against a phase-count reference model.
module tb_machine_ctl;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch;
  logic [2:0] opcode;
  logic       zero;
  logic       inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt;

  int checks = 0;
  int errors = 0;

  // Reference model: phase = cycles since the last accepted fetch rise.
  bit m_active = 1'b0;
  bit m_halted = 1'b0;
  bit m_prev   = 1'b0;
  int m_phase  = 0;

  machine_ctl dut (
    .clk         (clk),
    .reset       (reset),
    .fetch       (fetch),
    .opcode      (opcode),
    .zero        (zero),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_acc    (load_acc),
    .load_ir     (load_ir),
    .rd          (rd),
    .wr          (wr),
    .datactl_ena (datactl_ena),
    .halt        (halt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] observed();
    return {halt, inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena};
  endfunction

  // Bit order: halt, inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena.
  function automatic logic [7:0] model_out(input logic [2:0] op, input logic z);
    bit alu, sto, jmp, skz;
    int p;
    if (m_halted) return 8'b1000_0000;
    if (!m_active) return 8'b0;
    p   = m_phase;
    alu = (op >= 3'd2) && (op <= 3'd5);
    sto = (op == 3'd6);
    jmp = (op == 3'd7);
    skz = (op == 3'd1);
    return {1'b0,
            (p == 1) || (p == 3) || (p == 5 && (jmp || (skz && z))) || (p == 7 && skz && z),
            jmp && (p == 4 || p == 5),
            alu && (p == 5),
            (p <= 1),
            (p <= 1) || (alu && p >= 4 && p <= 6),
            sto && (p == 5),
            sto && p >= 4 && p <= 6};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (phase %0d)", tag, obs, exp, m_phase);
    end
  endtask

  task automatic cycle(input logic f, input logic [2:0] op, input logic z, input string tag);
    bit r;
    @(negedge clk);
    fetch  = f;
    opcode = op;
    zero   = z;
    @(posedge clk);
    #1;
    if (!reset) begin
      m_active = 1'b0;
      m_halted = 1'b0;
      m_prev   = 1'b0;
    end else begin
      r      = f && !m_prev;
      m_prev = f;
      if (!m_halted) begin
        if (r) begin
          m_active = 1'b1;
          m_phase  = 0;
        end else if (m_active) begin
          m_phase = (m_phase + 1) % 8;
        end
        if (m_active && m_phase == 3 && op == 3'd0) m_halted = 1'b1;
      end
    end
    check(tag, observed(), model_out(op, z));
    checks++;
    assert (!(rd === 1'b1 && wr === 1'b1))
    else begin
      errors++;
      $error("FAIL %s_rd_wr_excl observed rd=%b wr=%b expected not both 1", tag, rd, wr);
    end
  endtask

  task automatic instr(input logic [2:0] op, input logic z, input string tag);
    for (int i = 0; i < 8; i++) cycle(i < 4, op, z, tag);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check(tag, observed(), 8'b0);
    m_active = 1'b0;
    m_halted = 1'b0;
    m_prev   = 1'b0;
    cycle(1'b1, 3'd5, 1'b0, tag);
    @(negedge clk);
    fetch = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd5, 1'b0, {tag, "_idle"});
  endtask

  initial begin
    bit misalign_seq [13] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    reset  = 1'b0;
    fetch  = 1'b0;
    opcode = 3'd0;
    zero   = 1'b0;

    for (int i = 0; i < 3; i++) cycle(i[0], 3'd5, 1'b0, "reset");
    @(negedge clk);
    fetch = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) cycle(1'b0, 3'd5, 1'b0, "idle");

    instr(3'd5, 1'b0, "lda");
    instr(3'd5, 1'b1, "lda");
    instr(3'd6, 1'b0, "sto");
    instr(3'd1, 1'b1, "skz_zero");
    instr(3'd1, 1'b0, "skz_nonzero");
    instr(3'd7, 1'b0, "jmp");

    for (int n = 0; n < 24; n++)
      instr(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), "random");

    for (int i = 0; i < 13; i++) cycle(misalign_seq[i], 3'd6, 1'b0, "misalign");
    instr(3'd2, 1'b0, "after_misalign");

    for (int i = 0; i < 5; i++) cycle(i < 4, 3'd2, 1'b0, "add_partial");
    async_reset("mid_reset");
    instr(3'd5, 1'b0, "post_reset");

    instr(3'd0, 1'b0, "hlt");
    for (int n = 0; n < 20; n++)
      instr(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "halted");
    async_reset("halt_reset");
    instr(3'd5, 1'b0, "resume");
    instr(3'd4, 1'b1, "resume");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
